// File: rtl/i2c_read_arbiter_pkg.sv
// Shared definitions for the I2C read arbiter: FSM encoding, default timing
// constants and I2C address widths.
// Build option: define I2C_ARB_RETRY_EN to re-issue a timed-out read once
// before reporting an error.
package i2c_read_arbiter_pkg;

  localparam int DEF_TIMEOUT_CYC = 20000;
  localparam int DEF_GAP_CYC     = 4;
  localparam int DEV_AW          = 7;
  localparam int REG_AW          = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/i2c_read_arbiter_rr_arbiter_core.sv
// Combinational round-robin search: first set request bit at or after the
// pointer, wrapping modulo NUM_REQ.
module rr_arbiter_core
  import i2c_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Scan farthest-to-nearest so the closest set bit after ptr is the last write.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/i2c_read_arbiter.sv
// Shares one I2C random-read engine between NUM_REQ requesters with
// round-robin arbitration, timeout detection and an enable-low gap between
// transactions so the engine can reset.
// Build option: I2C_ARB_RETRY_EN -- re-issue once after the first timeout.
module i2c_read_arbiter
  import i2c_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DEV_AW-1:0] i_dev_addr,
  input  logic [NUM_REQ*REG_AW-1:0] i_reg_addr,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [7:0]                o_rsp_data,
  output logic                      o_rsp_err,
  output logic                      o_busy,
  output logic                      o_i2c_recv_en,
  output logic [DEV_AW-1:0]         o_i2c_dev_addr,
  output logic [REG_AW-1:0]         o_i2c_data_addr,
  input  logic [7:0]                i_i2c_read_data,
  input  logic                      i_i2c_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam int GAP_W = $clog2(GAP_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  state_t           state;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
`ifdef I2C_ARB_RETRY_EN
  logic             retry_used;  // this grant has already been re-issued once
  logic             reissue;     // leave GAP towards ISSUE instead of IDLE
`endif

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req         (i_req),
    .ptr         (ptr_q),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Transaction FSM; all engine-facing and response outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      ptr_q           <= '0;
      grant_q         <= '0;
      tmo_cnt         <= '0;
      gap_cnt         <= '0;
      o_rsp_valid     <= '0;
      o_rsp_data      <= '0;
      o_rsp_err       <= 1'b0;
      o_busy          <= 1'b0;
      o_i2c_recv_en   <= 1'b0;
      o_i2c_dev_addr  <= '0;
      o_i2c_data_addr <= '0;
`ifdef I2C_ARB_RETRY_EN
      retry_used      <= 1'b0;
      reissue         <= 1'b0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      o_rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q         <= arb_idx;
            o_i2c_dev_addr  <= i_dev_addr[int'(arb_idx)*DEV_AW +: DEV_AW];
            o_i2c_data_addr <= i_reg_addr[int'(arb_idx)*REG_AW +: REG_AW];
`ifdef I2C_ARB_RETRY_EN
            retry_used      <= 1'b0;
`endif
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_i2c_recv_en <= 1'b1;
          o_busy        <= 1'b1;
          tmo_cnt       <= '0;
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          // done is checked first so it wins over a coincident timeout
          if (i_i2c_done) begin
            o_rsp_valid <= NUM_REQ'(1) << grant_q;
            o_rsp_data  <= i_i2c_read_data;
            o_rsp_err   <= 1'b0;
            state       <= ST_RESP;
          end
`ifdef I2C_ARB_RETRY_EN
          else if (tmo_cnt == TMO_LAST && !retry_used) begin
            retry_used    <= 1'b1;
            reissue       <= 1'b1;
            o_i2c_recv_en <= 1'b0;
            gap_cnt       <= '0;
            state         <= ST_GAP;
          end
`endif
          else if (tmo_cnt == TMO_LAST) begin
            o_rsp_valid <= NUM_REQ'(1) << grant_q;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          o_i2c_recv_en <= 1'b0;
          ptr_q         <= (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
          gap_cnt       <= '0;
          state         <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
`ifdef I2C_ARB_RETRY_EN
            if (reissue) begin
              reissue <= 1'b0;
              state   <= ST_ISSUE;
            end else
`endif
            begin
              o_busy <= 1'b0;
              state  <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
